// File: rtl/gray_step_sched_if.sv
// Bundle between the step scheduler, its two requesters and the shared gray counter.
interface gray_step_sched_if #(
  parameter int unsigned STEP_W = 4,
  parameter int unsigned WRAP_W = 8
);
  logic              Req0;
  logic [STEP_W-1:0] Steps0;
  logic              Done0;
  logic              Req1;
  logic [STEP_W-1:0] Steps1;
  logic              Done1;
  logic              Clear;
  logic              CntEn;
  logic              CntReset;
  logic              CntOverflow;
  logic              Busy;
  logic              Owner;
  logic [WRAP_W-1:0] Wraps;

  modport slave (
    input  Req0, Steps0, Req1, Steps1, Clear, CntOverflow,
    output Done0, Done1, CntEn, CntReset, Busy, Owner, Wraps
  );

  modport master (
    output Req0, Steps0, Req1, Steps1, Clear, CntOverflow,
    input  Done0, Done1, CntEn, CntReset, Busy, Owner, Wraps
  );
endinterface

// File: rtl/gray_step_sched.sv
// Round-robin scheduler sharing one gray counter between two requesters;
// drives En for exactly the granted step count and counts counter wrap events.
module gray_step_sched #(
  parameter int unsigned STEP_W = 4,
  parameter int unsigned WRAP_W = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  gray_step_sched_if.slave     bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE, CLR} state_t;

  state_t            state_q, state_d;
  logic [STEP_W-1:0] remaining_q, remaining_d;
  logic              owner_q, owner_d;
  logic              last_owner_q, last_owner_d;
  logic              ov_prev_q, ov_prev_d;
  logic [WRAP_W-1:0] wraps_q, wraps_d;

  logic              winner;
  logic [STEP_W-1:0] winner_steps;

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    // Tie goes to whichever requester did not own the previous job.
    winner       = (bus.Req0 && bus.Req1) ? ~last_owner_q : bus.Req1;
    winner_steps = winner ? bus.Steps1 : bus.Steps0;

    unique case (state_q)
      IDLE: begin
        if (bus.Clear) begin
          state_d = CLR;
        end else if (bus.Req0 || bus.Req1) begin
          owner_d      = winner;
          last_owner_d = winner;
          remaining_d  = winner_steps;
          state_d      = (winner_steps != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        remaining_d = remaining_q - STEP_W'(1);
        if (remaining_q == STEP_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      CLR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_q == CLR) begin
      ov_prev_d = 1'b0;
      wraps_d   = '0;
    end else begin
      ov_prev_d = bus.CntOverflow;
      wraps_d   = wraps_q;
      if (bus.CntOverflow && !ov_prev_q && (wraps_q != '1)) begin
        wraps_d = wraps_q + WRAP_W'(1);
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= IDLE;
      remaining_q  <= '0;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      ov_prev_q    <= 1'b0;
      wraps_q      <= '0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      ov_prev_q    <= ov_prev_d;
      wraps_q      <= wraps_d;
    end
  end

  // Counter reset follows Reset combinationally so the counter clears on the next edge.
  assign bus.CntEn    = (state_q == RUN);
  assign bus.CntReset = (state_q == CLR) || Reset;
  assign bus.Done0    = (state_q == DONE) && !owner_q;
  assign bus.Done1    = (state_q == DONE) && owner_q;
  assign bus.Busy     = (state_q != IDLE);
  assign bus.Owner    = owner_q;
  assign bus.Wraps    = wraps_q;

endmodule

// File: tb/tb_gray_step_sched.sv
// Directed bench for gray_step_sched with a behavioural 3-bit gray counter attached.
module tb_gray_step_sched;

  logic Clk;
  logic Reset;

  gray_step_sched_if #(.STEP_W(4), .WRAP_W(8)) bus ();

  gray_step_sched #(.STEP_W(4), .WRAP_W(8)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Gray counter: sync reset, sticky overflow when advancing past the last code.
  logic [2:0] cnt_bin;
  logic       cnt_ov;
  logic [2:0] cnt_gray;
  logic       ov_mode;
  logic       ov_force;

  always @(posedge Clk) begin
    if (bus.CntReset) begin
      cnt_bin <= 3'd0;
      cnt_ov  <= 1'b0;
    end else if (bus.CntEn) begin
      if (cnt_bin == 3'd7) cnt_ov <= 1'b1;
      cnt_bin <= cnt_bin + 3'd1;
    end
  end

  assign cnt_gray        = cnt_bin ^ (cnt_bin >> 1);
  assign bus.CntOverflow = ov_mode ? ov_force : cnt_ov;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  // Called right after the grant edge; stops in the Done cycle (cyc = -1 on timeout).
  task automatic wait_done(output int en_cnt, output int cyc, output logic d0, output logic d1);
    en_cnt = 0;
    cyc    = -1;
    d0     = 1'b0;
    d1     = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (bus.Done0 || bus.Done1) begin
        cyc = c;
        d0  = bus.Done0;
        d1  = bus.Done1;
        break;
      end
      if (bus.CntEn) en_cnt++;
      tick();
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    #1;
    n_checks++; if (bus.CntReset !== 1'b1) begin n_fail++; $display("FAIL reset_cntreset: got %b expected 1", bus.CntReset); end
    n_checks++; if (bus.Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.Busy); end
    n_checks++; if (bus.CntEn !== 1'b0) begin n_fail++; $display("FAIL reset_cnten: got %b expected 0", bus.CntEn); end
    n_checks++; if (bus.Owner !== 1'b0) begin n_fail++; $display("FAIL reset_owner: got %b expected 0", bus.Owner); end
    n_checks++; if (bus.Wraps !== 8'd0) begin n_fail++; $display("FAIL reset_wraps: got %0d expected 0", bus.Wraps); end
    n_checks++; if ({bus.Done0, bus.Done1} !== 2'b00) begin n_fail++; $display("FAIL reset_done: got %b expected 00", {bus.Done0, bus.Done1}); end
    tick();
    tick();
    Reset = 1'b0;
    #1;
    n_checks++; if (bus.CntReset !== 1'b0) begin n_fail++; $display("FAIL reset_release: got %b expected 0", bus.CntReset); end
    n_checks++; if (cnt_gray !== 3'b000) begin n_fail++; $display("FAIL reset_counter: got %b expected 000", cnt_gray); end
  endtask

  task automatic test_single_job();
    logic [2:0] seq [5] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111};
    bus.Req0 = 1'b1; bus.Steps0 = 4'd5;
    tick();
    n_checks++; if (bus.Busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b expected 1", bus.Busy); end
    n_checks++; if (bus.CntEn !== 1'b1) begin n_fail++; $display("FAIL single_first_en: got %b expected 1", bus.CntEn); end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++; if (cnt_gray !== seq[i]) begin n_fail++; $display("FAIL single_gray[%0d]: got %b expected %b", i, cnt_gray, seq[i]); end
      if (i < 4) begin
        n_checks++; if ({bus.CntEn, bus.Done0} !== 2'b10) begin n_fail++; $display("FAIL single_run[%0d]: en,done got %b expected 10", i, {bus.CntEn, bus.Done0}); end
      end else begin
        n_checks++; if ({bus.CntEn, bus.Done0} !== 2'b01) begin n_fail++; $display("FAIL single_done: en,done got %b expected 01", {bus.CntEn, bus.Done0}); end
      end
    end
    bus.Req0 = 1'b0;
    tick();
    n_checks++; if (bus.Done0 !== 1'b0) begin n_fail++; $display("FAIL single_done_pulse: got %b expected 0", bus.Done0); end
    n_checks++; if (bus.Busy !== 1'b0) begin n_fail++; $display("FAIL single_idle_busy: got %b expected 0", bus.Busy); end
    n_checks++; if (bus.Owner !== 1'b0) begin n_fail++; $display("FAIL single_owner: got %b expected 0", bus.Owner); end
  endtask

  task automatic test_back_to_back();
    int en_cnt, cyc;
    logic d0, d1;
    do_reset();
    bus.Req0 = 1'b1; bus.Req1 = 1'b1; bus.Steps0 = 4'd2; bus.Steps1 = 4'd3;
    tick();
    n_checks++; if (bus.Owner !== 1'b0) begin n_fail++; $display("FAIL b2b_first_owner: got %b expected 0", bus.Owner); end
    wait_done(en_cnt, cyc, d0, d1);
    n_checks++; if (en_cnt !== 2) begin n_fail++; $display("FAIL b2b_en0: got %0d expected 2", en_cnt); end
    n_checks++; if (cyc !== 3) begin n_fail++; $display("FAIL b2b_lat0: got %0d expected 3", cyc); end
    n_checks++; if ({d0, d1} !== 2'b10) begin n_fail++; $display("FAIL b2b_done0: got %b expected 10", {d0, d1}); end
    bus.Req0 = 1'b0;
    tick();
    n_checks++; if ({bus.Busy, bus.Done0} !== 2'b00) begin n_fail++; $display("FAIL b2b_gap: busy,done0 got %b expected 00", {bus.Busy, bus.Done0}); end
    tick();
    n_checks++; if (bus.Owner !== 1'b1) begin n_fail++; $display("FAIL b2b_second_owner: got %b expected 1", bus.Owner); end
    wait_done(en_cnt, cyc, d0, d1);
    n_checks++; if (en_cnt !== 3) begin n_fail++; $display("FAIL b2b_en1: got %0d expected 3", en_cnt); end
    n_checks++; if (cyc !== 4) begin n_fail++; $display("FAIL b2b_lat1: got %0d expected 4", cyc); end
    n_checks++; if ({d0, d1} !== 2'b01) begin n_fail++; $display("FAIL b2b_done1: got %b expected 01", {d0, d1}); end
    bus.Req1 = 1'b0;
    tick();
    n_checks++; if (cnt_gray !== 3'b111) begin n_fail++; $display("FAIL b2b_counter: got %b expected 111", cnt_gray); end
    bus.Req0 = 1'b1; bus.Req1 = 1'b1; bus.Steps0 = 4'd1; bus.Steps1 = 4'd1;
    tick();
    n_checks++; if (bus.Owner !== 1'b0) begin n_fail++; $display("FAIL b2b_repeat_owner: got %b expected 0", bus.Owner); end
    wait_done(en_cnt, cyc, d0, d1);
    n_checks++; if ({d0, d1} !== 2'b10) begin n_fail++; $display("FAIL b2b_repeat_done: got %b expected 10", {d0, d1}); end
    bus.Req0 = 1'b0; bus.Req1 = 1'b0;
    tick();
  endtask

  task automatic test_zero_step();
    int en_cnt, cyc;
    logic d0, d1;
    // Counter sits at binary 6 (gray 101) after the back-to-back jobs.
    bus.Req1 = 1'b1; bus.Steps1 = 4'd0;
    tick();
    n_checks++; if (bus.Owner !== 1'b1) begin n_fail++; $display("FAIL zero_owner: got %b expected 1", bus.Owner); end
    wait_done(en_cnt, cyc, d0, d1);
    n_checks++; if (cyc !== 1) begin n_fail++; $display("FAIL zero_lat: got %0d expected 1", cyc); end
    n_checks++; if (en_cnt !== 0) begin n_fail++; $display("FAIL zero_en: got %0d expected 0", en_cnt); end
    n_checks++; if ({d0, d1} !== 2'b01) begin n_fail++; $display("FAIL zero_done: got %b expected 01", {d0, d1}); end
    bus.Req1 = 1'b0;
    tick();
    n_checks++; if (cnt_gray !== 3'b101) begin n_fail++; $display("FAIL zero_counter: got %b expected 101", cnt_gray); end
    n_checks++; if (bus.Busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy: got %b expected 0", bus.Busy); end
  endtask

  task automatic test_wrap_and_clear();
    int en_cnt, cyc;
    logic d0, d1;
    do_reset();
    bus.Req0 = 1'b1; bus.Steps0 = 4'd8;
    tick();
    wait_done(en_cnt, cyc, d0, d1);
    n_checks++; if (en_cnt !== 8) begin n_fail++; $display("FAIL wrap_en: got %0d expected 8", en_cnt); end
    n_checks++; if (cyc !== 9) begin n_fail++; $display("FAIL wrap_lat: got %0d expected 9", cyc); end
    n_checks++; if (cnt_gray !== 3'b000) begin n_fail++; $display("FAIL wrap_counter: got %b expected 000", cnt_gray); end
    n_checks++; if (bus.Wraps !== 8'd0) begin n_fail++; $display("FAIL wrap_not_yet: got %0d expected 0", bus.Wraps); end
    bus.Req0 = 1'b0;
    tick();
    n_checks++; if (bus.Wraps !== 8'd1) begin n_fail++; $display("FAIL wrap_count: got %0d expected 1", bus.Wraps); end
    tick();
    n_checks++; if (bus.Wraps !== 8'd1) begin n_fail++; $display("FAIL wrap_sticky_once: got %0d expected 1", bus.Wraps); end
    bus.Clear = 1'b1;
    tick();
    bus.Clear = 1'b0;
    n_checks++; if ({bus.CntReset, bus.Busy} !== 2'b11) begin n_fail++; $display("FAIL clr_state: cntreset,busy got %b expected 11", {bus.CntReset, bus.Busy}); end
    tick();
    n_checks++; if (bus.CntReset !== 1'b0) begin n_fail++; $display("FAIL clr_pulse: got %b expected 0", bus.CntReset); end
    n_checks++; if (bus.Wraps !== 8'd0) begin n_fail++; $display("FAIL clr_wraps: got %0d expected 0", bus.Wraps); end
    n_checks++; if (bus.CntOverflow !== 1'b0) begin n_fail++; $display("FAIL clr_overflow: got %b expected 0", bus.CntOverflow); end
    n_checks++; if (bus.Busy !== 1'b0) begin n_fail++; $display("FAIL clr_busy: got %b expected 0", bus.Busy); end
  endtask

  task automatic test_wrap_saturate();
    do_reset();
    ov_mode = 1'b1; ov_force = 1'b0;
    tick();
    for (int i = 0; i < 260; i++) begin
      ov_force = 1'b1;
      tick();
      if (i == 0) begin
        ov_force = 1'b1;
        tick();
        n_checks++; if (bus.Wraps !== 8'd1) begin n_fail++; $display("FAIL sat_level_once: got %0d expected 1", bus.Wraps); end
      end
      ov_force = 1'b0;
      tick();
      if (i == 253) begin
        n_checks++; if (bus.Wraps !== 8'd254) begin n_fail++; $display("FAIL sat_254: got %0d expected 254", bus.Wraps); end
      end
    end
    n_checks++; if (bus.Wraps !== 8'd255) begin n_fail++; $display("FAIL sat_hold: got %0d expected 255", bus.Wraps); end
    ov_mode = 1'b0;
    bus.Clear = 1'b1;
    tick();
    bus.Clear = 1'b0;
    tick();
    n_checks++; if (bus.Wraps !== 8'd0) begin n_fail++; $display("FAIL sat_clear: got %0d expected 0", bus.Wraps); end
  endtask

  task automatic test_clear_with_req();
    int en_cnt, cyc;
    logic d0, d1;
    bus.Clear = 1'b1; bus.Req0 = 1'b1; bus.Steps0 = 4'd1;
    tick();
    bus.Clear = 1'b0;
    n_checks++; if ({bus.CntReset, bus.CntEn} !== 2'b10) begin n_fail++; $display("FAIL clrreq_first: cntreset,en got %b expected 10", {bus.CntReset, bus.CntEn}); end
    tick();
    n_checks++; if ({bus.Busy, bus.CntReset} !== 2'b00) begin n_fail++; $display("FAIL clrreq_idle: busy,cntreset got %b expected 00", {bus.Busy, bus.CntReset}); end
    tick();
    n_checks++; if ({bus.Busy, bus.CntEn} !== 2'b11) begin n_fail++; $display("FAIL clrreq_grant: busy,en got %b expected 11", {bus.Busy, bus.CntEn}); end
    wait_done(en_cnt, cyc, d0, d1);
    n_checks++; if ({en_cnt, cyc} !== {32'd1, 32'd2}) begin n_fail++; $display("FAIL clrreq_job: en=%0d cyc=%0d expected en=1 cyc=2", en_cnt, cyc); end
    n_checks++; if (d0 !== 1'b1) begin n_fail++; $display("FAIL clrreq_done: got %b expected 1", d0); end
    bus.Req0 = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_run();
    bus.Req0 = 1'b1; bus.Steps0 = 4'd7;
    tick();
    tick();
    bus.Req0 = 1'b0;
    n_checks++; if ({bus.CntEn, cnt_gray} !== 4'b1_011) begin n_fail++; $display("FAIL midrun_pre: en,cnt got %b expected 1011", {bus.CntEn, cnt_gray}); end
    Reset = 1'b1;
    #1;
    n_checks++; if ({bus.CntEn, bus.Busy, bus.Done0} !== 3'b000) begin n_fail++; $display("FAIL midrun_abort: en,busy,done0 got %b expected 000", {bus.CntEn, bus.Busy, bus.Done0}); end
    n_checks++; if (bus.Wraps !== 8'd0) begin n_fail++; $display("FAIL midrun_wraps: got %0d expected 0", bus.Wraps); end
    n_checks++; if (bus.CntReset !== 1'b1) begin n_fail++; $display("FAIL midrun_cntreset: got %b expected 1", bus.CntReset); end
    tick();
    n_checks++; if (cnt_gray !== 3'b000) begin n_fail++; $display("FAIL midrun_counter: got %b expected 000", cnt_gray); end
    Reset = 1'b0;
    tick();
    n_checks++; if ({bus.Busy, bus.Done0} !== 2'b00) begin n_fail++; $display("FAIL midrun_after: busy,done0 got %b expected 00", {bus.Busy, bus.Done0}); end
  endtask

  initial begin
    Reset      = 1'b1;
    bus.Req0   = 1'b0;
    bus.Req1   = 1'b0;
    bus.Steps0 = 4'd0;
    bus.Steps1 = 4'd0;
    bus.Clear  = 1'b0;
    ov_mode    = 1'b0;
    ov_force   = 1'b0;
    test_reset();
    test_single_job();
    test_back_to_back();
    test_zero_step();
    test_wrap_and_clear();
    test_wrap_saturate();
    test_clear_with_req();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
